// File: rtl/sm_debug_ctrl.sv
// Debug/run controller: debounced single-step key, HALT/STEP/RUN clock-enable sequencing,
// and manual or auto-scanned register-file readout latched for the display path.
module sm_debug_ctrl #(
  parameter int DEBOUNCE_MAX = 50000,
  parameter int SCAN_PERIOD  = 25000000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stepKey_n,
  input  logic        runSw,
  input  logic        scanSw,
  input  logic [4:0]  manualAddr,
  input  logic        coreClk,
  input  logic [31:0] regData,
  output logic        clkEnable,
  output logic [4:0]  regAddr,
  output logic [31:0] dispData,
  output logic [4:0]  dispAddr,
  output logic [15:0] stepCount
);

  localparam logic [CNT_W-1:0] DB_MAX    = CNT_W'(DEBOUNCE_MAX);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_PERIOD - 1);
  // Synchroniser bit order {key, run, scan, addr[4:0], core}; the key is active-low.
  localparam logic [8:0]       SYNC_RST  = 9'h100;

  typedef enum logic [1:0] {HALT, STEP, RUN} state_t;

  state_t           state_q, state_d;
  logic [8:0]       sync1_q, sync1_d;
  logic [8:0]       sync2_q, sync2_d;
  logic             core_hist_q, core_hist_d;
  logic             key_db_q, key_db_d;
  logic             step_pulse_q, step_pulse_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic             clk_en_q, clk_en_d;
  logic [4:0]       reg_addr_q, reg_addr_d;
  logic [31:0]      disp_data_q, disp_data_d;
  logic [4:0]       disp_addr_q, disp_addr_d;
  logic [15:0]      step_cnt_q, step_cnt_d;

  logic       key_s, run_s, scan_s, core_s, core_rise;
  logic [4:0] addr_s;

  assign {key_s, run_s, scan_s, addr_s, core_s} = sync2_q;
  assign core_rise = core_s & ~core_hist_q;

  always_comb begin
    sync1_d      = {stepKey_n, runSw, scanSw, manualAddr, coreClk};
    sync2_d      = sync1_q;
    core_hist_d  = core_s;
    key_db_d     = key_db_q;
    step_pulse_d = 1'b0;
    db_cnt_d     = '0;
    // A level is accepted only after DEBOUNCE_MAX+1 consecutive differing samples.
    if (key_s != key_db_q) begin
      if (db_cnt_q == DB_MAX) begin
        key_db_d     = key_s;
        step_pulse_d = ~key_s;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    unique case (state_q)
      HALT: begin
        if (run_s) state_d = RUN;
        else if (step_pulse_q) state_d = STEP;
      end
      STEP: begin
        if (core_rise) begin
          state_d    = HALT;
          step_cnt_d = step_cnt_q + 16'd1;
        end
      end
      RUN: begin
        if (!run_s) state_d = HALT;
      end
      default: state_d = HALT;
    endcase
    // Registered so the enable into the core never glitches on state decode.
    clk_en_d = (state_d != HALT);
  end

  always_comb begin
    reg_addr_d  = reg_addr_q;
    disp_data_d = disp_data_q;
    disp_addr_d = disp_addr_q;
    scan_cnt_d  = '0;
    if (!scan_s) begin
      reg_addr_d  = addr_s;
      disp_data_d = regData;
      disp_addr_d = reg_addr_q;
    end else if (scan_cnt_q == SCAN_LAST) begin
      reg_addr_d  = reg_addr_q + 5'd1;
      disp_data_d = regData;
      disp_addr_d = reg_addr_q;
    end else begin
      scan_cnt_d = scan_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= HALT;
      sync1_q      <= SYNC_RST;
      sync2_q      <= SYNC_RST;
      core_hist_q  <= 1'b0;
      key_db_q     <= 1'b1;
      step_pulse_q <= 1'b0;
      db_cnt_q     <= '0;
      scan_cnt_q   <= '0;
      clk_en_q     <= 1'b0;
      reg_addr_q   <= '0;
      disp_data_q  <= '0;
      disp_addr_q  <= '0;
      step_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      core_hist_q  <= core_hist_d;
      key_db_q     <= key_db_d;
      step_pulse_q <= step_pulse_d;
      db_cnt_q     <= db_cnt_d;
      scan_cnt_q   <= scan_cnt_d;
      clk_en_q     <= clk_en_d;
      reg_addr_q   <= reg_addr_d;
      disp_data_q  <= disp_data_d;
      disp_addr_q  <= disp_addr_d;
      step_cnt_q   <= step_cnt_d;
    end
  end

  assign clkEnable = clk_en_q;
  assign regAddr   = reg_addr_q;
  assign dispData  = disp_data_q;
  assign dispAddr  = disp_addr_q;
  assign stepCount = step_cnt_q;

endmodule

// File: tb/tb_sm_debug_ctrl.sv
// Bench for sm_debug_ctrl: cycle model built from input delay histories plus directed scenarios.
module tb_sm_debug_ctrl;
  localparam int D = 8;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_key_n = 1'b1;
  logic        run_sw = 1'b0;
  logic        scan_sw = 1'b0;
  logic [4:0]  manual_addr = 5'd0;
  logic        core_clk = 1'b0;
  logic [31:0] reg_data;
  logic        clk_en;
  logic [4:0]  reg_addr, disp_addr;
  logic [31:0] disp_data;
  logic [15:0] step_count;

  assign reg_data = {27'b0, reg_addr} + 32'h100;
  always #5 clk = ~clk;

  sm_debug_ctrl #(.DEBOUNCE_MAX(D), .SCAN_PERIOD(P), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .stepKey_n(step_key_n), .runSw(run_sw), .scanSw(scan_sw),
    .manualAddr(manual_addr), .coreClk(core_clk), .regData(reg_data),
    .clkEnable(clk_en), .regAddr(reg_addr), .dispData(disp_data), .dispAddr(disp_addr),
    .stepCount(step_count)
  );

  // Core divider stand-in: toggles every 4 enabled clk cycles; core_hold freezes it.
  logic core_hold = 1'b0;
  int   core_div = 0;
  int   core_rises = 0;
  always @(negedge clk) begin
    if (clk_en && !core_hold) begin
      if (core_div == 3) begin
        core_div = 0;
        core_clk = ~core_clk;
        if (core_clk) core_rises++;
      end else begin
        core_div++;
      end
    end
  end

  int n_pass = 0, n_total = 0, cyc = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Behavioural model
  typedef enum {M_HALT, M_STEP, M_RUN} mstate_t;
  mstate_t     m_state;
  int          m_steps, m_diff_run, m_age;
  logic        m_db, m_pulse;
  logic [4:0]  m_addr, m_disp_addr;
  logic [31:0] m_disp_data;
  // Input samples taken at the last three edges, index 0 newest.
  logic        key_h[3]  = '{1'b1, 1'b1, 1'b1};
  logic        run_h[3]  = '{1'b0, 1'b0, 1'b0};
  logic        scan_h[3] = '{1'b0, 1'b0, 1'b0};
  logic        core_h[3] = '{1'b0, 1'b0, 1'b0};
  logic [4:0]  addr_h[3] = '{5'd0, 5'd0, 5'd0};

  task automatic model_edge();
    logic key_s, run_s, scan_s, rise;
    logic [4:0] addr_s, old;
    key_s  = key_h[1];
    run_s  = run_h[1];
    scan_s = scan_h[1];
    addr_s = addr_h[1];
    rise   = core_h[1] & ~core_h[2];
    old    = m_addr;
    if (!rst_n) begin
      m_state = M_HALT; m_steps = 0; m_db = 1'b1; m_pulse = 1'b0; m_diff_run = 0; m_age = 0;
      m_addr = 5'd0; m_disp_addr = 5'd0; m_disp_data = 32'd0;
      for (int i = 0; i < 3; i++) begin
        key_h[i] = 1'b1; run_h[i] = 1'b0; scan_h[i] = 1'b0; core_h[i] = 1'b0; addr_h[i] = 5'd0;
      end
    end else begin
      case (m_state)
        M_HALT: if (run_s) m_state = M_RUN; else if (m_pulse) m_state = M_STEP;
        M_STEP: if (rise) begin m_state = M_HALT; m_steps = (m_steps + 1) % 65536; end
        M_RUN:  if (!run_s) m_state = M_HALT;
        default: m_state = M_HALT;
      endcase
      m_pulse = 1'b0;
      if (key_s != m_db) m_diff_run++;
      else m_diff_run = 0;
      if (m_diff_run == D + 1) begin
        m_db = key_s; m_diff_run = 0; m_pulse = ~key_s;
      end
      if (!scan_s) begin
        m_addr = addr_s; m_disp_addr = old; m_disp_data = {27'b0, old} + 32'h100; m_age = 0;
      end else begin
        if (m_age % P == P - 1) begin
          m_disp_addr = old; m_disp_data = {27'b0, old} + 32'h100; m_addr = old + 5'd1;
        end
        m_age++;
      end
      for (int i = 2; i > 0; i--) begin
        key_h[i] = key_h[i-1]; run_h[i] = run_h[i-1]; scan_h[i] = scan_h[i-1];
        core_h[i] = core_h[i-1]; addr_h[i] = addr_h[i-1];
      end
      key_h[0] = step_key_n; run_h[0] = run_sw; scan_h[0] = scan_sw;
      core_h[0] = core_clk; addr_h[0] = manual_addr;
    end
  endtask

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("clkEnable", 32'(clk_en), 32'(m_state != M_HALT));
      check("stepCount", 32'(step_count), 32'(m_steps));
      check("regAddr", 32'(reg_addr), 32'(m_addr));
      check("dispAddr", 32'(disp_addr), 32'(m_disp_addr));
      check("dispData", disp_data, m_disp_data);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic press(int low, int high);
    step_key_n = 1'b0; tick(low);
    step_key_n = 1'b1; tick(high);
  endtask

  initial begin
    int t0, rise_cyc, n_rise, n_adv, dwell;
    logic prev_en;
    logic [4:0] exp_prev, exp_next, last_addr;

    for (int i = 0; i < 3; i++) begin
      step_key_n = 1'($urandom); run_sw = 1'($urandom); scan_sw = 1'($urandom);
      manual_addr = 5'($urandom);
      tick(1);
      chk_en = 1'b1;
    end
    check("rst clkEnable", 32'(clk_en), 32'd0);
    check("rst regAddr", 32'(reg_addr), 32'd0);
    check("rst dispData", disp_data, 32'd0);
    check("rst dispAddr", 32'(disp_addr), 32'd0);
    check("rst stepCount", 32'(step_count), 32'd0);
    step_key_n = 1'b1; run_sw = 1'b0; scan_sw = 1'b0; manual_addr = 5'd0; rst_n = 1'b1;
    tick(6);
    check("released clkEnable", 32'(clk_en), 32'd0);

    // Bouncy press: 5 low, 2 high, then a long low.
    step_key_n = 1'b0; tick(5);
    step_key_n = 1'b1; tick(2);
    step_key_n = 1'b0; t0 = cyc; rise_cyc = -1; n_rise = 0; prev_en = clk_en;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (clk_en && !prev_en) begin
        n_rise++;
        if (rise_cyc < 0) rise_cyc = cyc;
      end
      prev_en = clk_en;
    end
    step_key_n = 1'b1; tick(20);
    check("debounce step count", 32'(n_rise), 32'd1);
    // 2 sync + 8 debounce + 1 to the pulse, then 1 more to clkEnable.
    check("debounce latency", 32'(rise_cyc - t0), 32'd12);
    check("debounce stepCount", 32'(step_count), 32'd1);

    // Single steps: two clean, one with a press landing inside a held STEP.
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    check("re-rst stepCount", 32'(step_count), 32'd0);
    tick(3);
    core_rises = 0;
    press(14, 14);
    press(14, 14);
    check("two steps", 32'(step_count), 32'd2);
    core_hold = 1'b1;
    step_key_n = 1'b0; tick(14);
    check("held STEP clkEnable", 32'(clk_en), 32'd1);
    step_key_n = 1'b1; tick(14);
    press(14, 14);
    check("ignored press stepCount", 32'(step_count), 32'd2);
    core_hold = 1'b0; tick(20);
    check("three steps", 32'(step_count), 32'd3);
    check("core rises", 32'(core_rises), 32'd3);
    check("halt after steps", 32'(clk_en), 32'd0);

    // Reset in the middle of a STEP.
    core_hold = 1'b1;
    step_key_n = 1'b0; tick(14);
    check("pre-reset STEP", 32'(clk_en), 32'd1);
    rst_n = 1'b0; tick(1);
    check("mid-STEP rst clkEnable", 32'(clk_en), 32'd0);
    check("mid-STEP rst stepCount", 32'(step_count), 32'd0);
    rst_n = 1'b1; step_key_n = 1'b1; tick(14);
    core_hold = 1'b0; tick(10);
    check("stays halted", 32'(clk_en), 32'd0);

    // Run/halt.
    run_sw = 1'b1; tick(2);
    check("run +2", 32'(clk_en), 32'd0);
    tick(1);
    check("run +3", 32'(clk_en), 32'd1);
    press(14, 14);
    check("run ignores key", 32'(step_count), 32'd0);
    run_sw = 1'b0; tick(2);
    check("halt +2", 32'(clk_en), 32'd1);
    tick(1);
    check("halt +3", 32'(clk_en), 32'd0);
    tick(10);

    // Scan through all registers and past the wrap.
    manual_addr = 5'd0; tick(4);
    scan_sw = 1'b1;
    n_adv = 0; dwell = 0; exp_prev = 5'd0; last_addr = reg_addr;
    for (int i = 0; i < 200 && n_adv < 34; i++) begin
      tick(1); dwell++;
      if (reg_addr != last_addr) begin
        exp_next = exp_prev + 5'd1;
        check("scan regAddr", 32'(reg_addr), 32'(exp_next));
        check("scan dispAddr", 32'(disp_addr), 32'(exp_prev));
        check("scan dispData", disp_data, 32'h100 + 32'(exp_prev));
        if (n_adv > 0) check("scan dwell", 32'(dwell), 32'(P));
        if (exp_prev == 5'd31) check("scan wrap", 32'(reg_addr), 32'd0);
        n_adv++; dwell = 0; exp_prev = exp_next; last_addr = reg_addr;
      end
    end
    check("scan advances", 32'(n_adv), 32'd34);

    // Leave scan mode at address 7.
    for (int i = 0; i < 200 && reg_addr != 5'd7; i++) tick(1);
    check("scan reached 7", 32'(reg_addr), 32'd7);
    scan_sw = 1'b0; manual_addr = 5'h15;
    tick(3);
    check("manual regAddr", 32'(reg_addr), 32'h15);
    tick(1);
    check("manual dispAddr", 32'(disp_addr), 32'h15);
    check("manual dispData", disp_data, 32'h115);
    tick(4);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/sm_debug_ctrl.md
# sm_debug_ctrl

Debug/run controller placed between the board top-level and `sm_top`. It debounces the step key, sequences the core's clock enable (free-run, halt or exactly one core-clock step per key press), and drives the core's register-file debug port `regAddr`. It drives `regAddr` either from switches or by auto-scanning all 32 registers, and latches the matching `regData` for the 7-segment/LED display path.

## Interface
Parameters:
- `DEBOUNCE_MAX`, default 50000: number of consecutive stable `clk` cycles before a key level change is accepted.
- `SCAN_PERIOD`, default 25000000: `clk` cycles spent on each register address in scan mode. Must be ≥ 2.
- `CNT_W`, default 26: width of the internal debounce and scan counters. Must hold `max(DEBOUNCE_MAX, SCAN_PERIOD)`.

Ports:
- `clk`, input, 1: board clock (`clkIn` domain). Every flop is clocked on the rising edge.
- `rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `stepKey_n`, input, 1: raw, asynchronous, active-low step pushbutton.
- `runSw`, input, 1: raw, asynchronous run switch. 1 = free-run, 0 = halt/step.
- `scanSw`, input, 1: raw, asynchronous scan switch. 1 = auto-scan, 0 = manual address.
- `manualAddr`, input, 5: register address from switches (asynchronous).
- `coreClk`, input, 1: divided core clock from `sm_top`, sampled as data.
- `regData`, input, 32: register-file debug read data for the current `regAddr`.
- `clkEnable`, output, 1: clock enable to `sm_top`.
- `regAddr`, output, 5: register-file debug address to `sm_top`.
- `dispData`, output, 32: latched register value for display.
- `dispAddr`, output, 5: address that `dispData` belongs to.
- `stepCount`, output, 16: number of completed single steps, wraps.

## Operation
- **Input synchronisers:** `stepKey_n`, `runSw`, `scanSw` and `manualAddr` each pass through a 2-flop synchroniser. `coreClk` passes through a 2-flop synchroniser plus one history flop for edge detection.
- **Debounce (key only):**
  - The debounced level `keyDb` resets to 1 (released).
  - The counter clears whenever the synced level equals `keyDb`; otherwise it increments.
  - When the counter reaches `DEBOUNCE_MAX`, `keyDb` takes the synced level and the counter clears.
  - `stepPulse` is a one-cycle pulse on each 1→0 transition of `keyDb`.
- **Clock FSM (states HALT, STEP, RUN), reset to HALT:**
  - HALT: `clkEnable`=0. `runSw`=1 → RUN. Else `stepPulse` → STEP.
  - STEP: `clkEnable`=1. A rising edge on synced `coreClk` → HALT and `stepCount`+1. `runSw` and `stepPulse` are ignored while in STEP.
  - RUN: `clkEnable`=1. `runSw`=0 → HALT. `stepPulse` is ignored. `stepCount` is unchanged.
  - If `runSw` goes 1 and `stepPulse` arrives in the same HALT cycle, RUN wins and the step is discarded.
- **Register scan:**
  - Manual mode (`scanSw`=0):
    - `regAddr` <= synced `manualAddr` each cycle; the scan counter is held at 0.
    - `dispData` <= `regData` and `dispAddr` <= `regAddr` each cycle, so the display lags the address by 1 cycle.
  - Scan mode (`scanSw`=1):
    - The scan counter counts 0..`SCAN_PERIOD`-1.
    - At count `SCAN_PERIOD`-1, `dispData` <= `regData`, `dispAddr` <= `regAddr`, `regAddr` <= `regAddr`+1 (31 wraps to 0), and the counter returns to 0.
    - `dispData`/`dispAddr` are otherwise held.
  - Entering scan mode continues from the current `regAddr`. Leaving scan mode takes `manualAddr` on the next cycle.
- `stepCount` is 16-bit modulo: 0xFFFF+1 = 0x0000.

## Timing
- Reset values (synchronous, `rst_n`=0 at a rising edge): FSM=HALT, `clkEnable`=0, `regAddr`=0, `dispData`=0, `dispAddr`=0, `stepCount`=0, `keyDb`=1, all counters and synchroniser flops cleared. Synchroniser flops for active-low inputs reset to 1.
- Reset asserted mid-STEP forces HALT on that edge, with no `stepCount` increment.
- Key latency: raw press → `stepPulse` = 2 (sync) + `DEBOUNCE_MAX` + 1 cycles, given the key stays stable. Any bounce restarts the count.
- Step latency:
  - `stepPulse` → `clkEnable`=1 on the next cycle.
  - `clkEnable` falls on the cycle after the synced `coreClk` rising edge is detected.
  - Exactly one core rising edge occurs per step, provided the core divider is ≥ 4 `clk` cycles per half-period. Faster dividers are unsupported in step mode.
- `runSw` change → `clkEnable` change: 3 cycles (2 sync + 1 FSM).
- Scan: each address is presented for exactly `SCAN_PERIOD` cycles. `regData` is sampled on the last cycle of that window.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs → all outputs 0, FSM HALT. Release with `runSw`=0 → `clkEnable` stays 0.
- Debounce with `DEBOUNCE_MAX`=8: drive `stepKey_n` low for 5 cycles, high for 2, then low for 20 → exactly one `stepPulse`, occurring 2+8+1 cycles after the final low transition.
- Single step with `coreClk` toggling every 4 cycles:
  - Three clean presses → `stepCount`=3.
  - Exactly 3 `coreClk` rising edges observed while `clkEnable`=1.
  - A press during STEP is ignored.
- Run/halt: `runSw`=1 → `clkEnable`=1 after 3 cycles; key presses leave `stepCount` unchanged. `runSw`=0 → `clkEnable`=0 after 3 cycles.
- Scan with `SCAN_PERIOD`=4 and `regData`={27'b0,`regAddr`}+0x100:
  - `regAddr` steps 0,1,…,31,0.
  - `dispAddr`=n is paired with `dispData`=0x100+n.
  - The 31→0 wrap is verified.
- Mode switch: in scan mode at `regAddr`=7, set `scanSw`=0 with `manualAddr`=0x15 → `regAddr`=0x15 three cycles later and `dispAddr`=0x15 one cycle after that.
